fetch_ext_rd: RTL and testbench

- Responder end of the luma search-window fetch "ext" load interface.
- Accepts one macroblock load request (ext_start_i with MB x/y) and reads the 16x16 luma MB from frame memory through a pipelined read port.
- Streams the MB back as 32 beats of 8 pixels in the ordering the search-window RAM writer expects, then pulses ext_done_o.
- Sits between the fetch_luma-side ext port and the external memory arbiter.

---
 rtl/fetch_ext_rd_pkg.sv | 31 +++
 rtl/fetch_ext_agen.sv | 61 ++++++
 rtl/fetch_ext_rd.sv | 179 +++++++++++++++++
 tb/tb_fetch_ext_rd.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ext_rd_pkg.sv
// rtl/fetch_ext_rd_pkg.sv - shared widths, beat count and FSM encoding for fetch_ext_rd
//
// Purpose: picture-size and pixel-depth macros plus package constants and the
//          load FSM state type, shared by fetch_ext_rd and fetch_ext_agen.
// Ports:   none (package).
`ifndef PIC_W_MB_LEN
`define PIC_W_MB_LEN 8
`endif
`ifndef PIC_H_MB_LEN
`define PIC_H_MB_LEN 8
`endif
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

package fetch_ext_rd_pkg;

    // One 16x16 MB = 16 rows x 2 halves of 8 pixels.
    localparam int BEATS      = 32;
    localparam int BEAT_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_REQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_HOLD  = 3'd5
    } state_e;

endpackage

// File: rtl/fetch_ext_agen.sv
// rtl/fetch_ext_agen.sv - incremental read-address generator for one MB load
//
// Purpose: produces the 8-byte read address for beat index beat_i of the MB
//          starting at row0. Beat k reads row 4*(k/8)+k%4, half (k/4)%2.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture row0_i as the first group's row pointer
//   row0_i       byte address of MB row 0
//   stride_i     picture line stride in bytes
//   adv_i        current beat's request accepted
//   beat_i       index of the beat currently being requested
//   addr_o       read address for beat_i
module fetch_ext_agen
    import fetch_ext_rd_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_W-1:0]     row0_i,
    input  logic [ADDR_W-1:0]     stride_i,
    input  logic                  adv_i,
    input  logic [BEAT_CNT_W-1:0] beat_i,
    output logic [ADDR_W-1:0]     addr_o
);

    logic [ADDR_W-1:0] grp_q, grp_d;
    logic [ADDR_W-1:0] row_off;

    // Group pointer steps down four lines after the 8th beat of each group.
    always_comb begin
        grp_d = grp_q;
        if (load_i) begin
            grp_d = row0_i;
        end else if (adv_i && (beat_i[2:0] == 3'd7)) begin
            grp_d = grp_q + (stride_i << 2);
        end
    end

    // Row within the group is 0..3, so the offset is a shift-add, not a multiply.
    always_comb begin
        case (beat_i[1:0])
            2'd0:    row_off = '0;
            2'd1:    row_off = stride_i;
            2'd2:    row_off = stride_i << 1;
            default: row_off = stride_i + (stride_i << 1);
        endcase
    end

    assign addr_o = grp_q + row_off + (beat_i[2] ? ADDR_W'(8) : ADDR_W'(0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q <= '0;
        end else begin
            grp_q <= grp_d;
        end
    end

endmodule

// File: rtl/fetch_ext_rd.sv
// rtl/fetch_ext_rd.sv - responder for the luma search-window ext MB load port
//
// Purpose: on ext_start_i, reads the 16x16 luma MB at (mb_x, mb_y) from frame
//          memory as 32 8-byte reads, streams them back on ext_valid_o/ext_data_o,
//          then pulses ext_done_o. Optional macro FETCH_EXT_CLAMP_EN clamps the
//          latched MB coordinates to the picture size.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   sys_total_x/y                picture size in MBs minus 1
//   sys_ref_base_i               reference luma plane base (8-byte aligned)
//   ext_start_i, ext_mb_x/y_i    load request level and MB coordinates
//   ext_valid_o, ext_data_o      returned beats, leftmost pixel in LSBs
//   ext_done_o                   one-cycle load-complete pulse
//   mem_req_o, mem_addr_o, mem_ack_i        read request channel
//   mem_rvalid_i, mem_rdata_i               in-order read return channel
`ifndef PIC_W_MB_LEN
`define PIC_W_MB_LEN 8
`endif
`ifndef PIC_H_MB_LEN
`define PIC_H_MB_LEN 8
`endif
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module fetch_ext_rd
    import fetch_ext_rd_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [`PIC_W_MB_LEN-1:0] sys_total_x,
    input  logic [`PIC_H_MB_LEN-1:0] sys_total_y,
    input  logic [ADDR_W-1:0]        sys_ref_base_i,
    input  logic                     ext_start_i,
    input  logic [`PIC_W_MB_LEN-1:0] ext_mb_x_i,
    input  logic [`PIC_H_MB_LEN-1:0] ext_mb_y_i,
    output logic                     ext_valid_o,
    output logic [8*`BIT_DEPTH-1:0]  ext_data_o,
    output logic                     ext_done_o,
    output logic                     mem_req_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic                     mem_rvalid_i,
    input  logic [8*`BIT_DEPTH-1:0]  mem_rdata_i
);

    state_e                   state_q, state_d;
    logic [`PIC_W_MB_LEN-1:0] mb_x_q, mb_x_d, x_lat;
    logic [`PIC_H_MB_LEN-1:0] mb_y_q, mb_y_d, y_lat;
    logic [BEAT_CNT_W-1:0]    req_cnt_q, req_cnt_d;
    logic [BEAT_CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [2:0]               outst_q, outst_d;
    logic                     valid_q, valid_d;
    logic [8*`BIT_DEPTH-1:0]  data_q, data_d;

    logic [ADDR_W-1:0]        stride, row0;
    logic                     load, ack, rv_take, accept;

`ifdef FETCH_EXT_CLAMP_EN
    assign x_lat = (ext_mb_x_i > sys_total_x) ? sys_total_x : ext_mb_x_i;
    assign y_lat = (ext_mb_y_i > sys_total_y) ? sys_total_y : ext_mb_y_i;
`else
    logic unused_total_y;
    assign unused_total_y = ^sys_total_y;
    assign x_lat = ext_mb_x_i;
    assign y_lat = ext_mb_y_i;
`endif

    assign stride = (ADDR_W'(sys_total_x) + ADDR_W'(1)) << 4;
    assign row0   = sys_ref_base_i + ((ADDR_W'(mb_y_q) * stride) << 4)
                  + (ADDR_W'(mb_x_q) << 4);

    // A return with nothing outstanding (e.g. left over from before a reset)
    // is dropped entirely and never reaches the output.
    assign rv_take = mem_rvalid_i && (outst_q != 3'd0);
    assign accept  = rv_take && ((state_q == ST_REQ) || (state_q == ST_DRAIN));
    assign ack     = mem_req_o && mem_ack_i;

    always_comb begin
        state_d    = state_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        req_cnt_d  = req_cnt_q;
        beat_cnt_d = beat_cnt_q;
        mem_req_o  = 1'b0;
        ext_done_o = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ext_start_i) begin
                    mb_x_d     = x_lat;
                    mb_y_d     = y_lat;
                    req_cnt_d  = '0;
                    beat_cnt_d = '0;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                load    = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                mem_req_o = (req_cnt_q < BEAT_CNT_W'(BEATS)) && (outst_q < 3'(MAX_OUTST));
                if (req_cnt_q == BEAT_CNT_W'(BEATS)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat_cnt_q == BEAT_CNT_W'(BEATS)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ext_done_o = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (!ext_start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ack) begin
            req_cnt_d = req_cnt_q + BEAT_CNT_W'(1);
        end
        if (accept) begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
        end
    end

    assign outst_d = outst_q + {2'b00, ack} - {2'b00, rv_take};
    assign valid_d = accept;
    assign data_d  = accept ? mem_rdata_i : '0;

    fetch_ext_agen #(
        .ADDR_W (ADDR_W)
    ) u_agen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .row0_i   (row0),
        .stride_i (stride),
        .adv_i    (ack),
        .beat_i   (req_cnt_q),
        .addr_o   (mem_addr_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mb_x_q     <= '0;
            mb_y_q     <= '0;
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            outst_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            mb_x_q     <= mb_x_d;
            mb_y_q     <= mb_y_d;
            req_cnt_q  <= req_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            outst_q    <= outst_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign ext_valid_o = valid_q;
    assign ext_data_o  = data_q;

endmodule

// File: tb/tb_fetch_ext_rd.sv
// tb/tb_fetch_ext_rd.sv - directed self-checking bench for fetch_ext_rd
`ifndef PIC_W_MB_LEN
`define PIC_W_MB_LEN 8
`endif
`ifndef PIC_H_MB_LEN
`define PIC_H_MB_LEN 8
`endif
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module tb_fetch_ext_rd;

    localparam int          ADDR_W = 32;
    localparam int          DW     = 8 * `BIT_DEPTH;
    localparam logic [31:0] BASE   = 32'h1000;
    localparam logic [31:0] STRIDE = 32'd160;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [`PIC_W_MB_LEN-1:0] sys_total_x;
    logic [`PIC_H_MB_LEN-1:0] sys_total_y;
    logic [ADDR_W-1:0]        sys_ref_base_i;
    logic                     ext_start_i;
    logic [`PIC_W_MB_LEN-1:0] ext_mb_x_i;
    logic [`PIC_H_MB_LEN-1:0] ext_mb_y_i;
    logic                     ext_valid_o;
    logic [DW-1:0]            ext_data_o;
    logic                     ext_done_o;
    logic                     mem_req_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic                     mem_ack_i;
    logic                     mem_rvalid_i;
    logic [DW-1:0]            mem_rdata_i;

    always #5 clk = ~clk;

    fetch_ext_rd #(.ADDR_W(ADDR_W), .MAX_OUTST(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sys_total_x    (sys_total_x),
        .sys_total_y    (sys_total_y),
        .sys_ref_base_i (sys_ref_base_i),
        .ext_start_i    (ext_start_i),
        .ext_mb_x_i     (ext_mb_x_i),
        .ext_mb_y_i     (ext_mb_y_i),
        .ext_valid_o    (ext_valid_o),
        .ext_data_o     (ext_data_o),
        .ext_done_o     (ext_done_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] row0, input int k);
        int g, h, r;
        g = k / 8;
        h = (k / 4) % 2;
        r = 4 * g + k % 4;
        return row0 + 32'(r) * STRIDE + 32'(8 * h);
    endfunction

    // Memory responder: acks every request (except a scripted hold), returns
    // data {addr, ~addr} two cycles later in order, optionally with random gaps.
    logic [31:0] acked[$];
    logic [31:0] pipe_a[$];
    int          pipe_t[$];
    int          ncyc = 0;
    int          model_outst = 0;
    bit          gap_en = 0;
    int          hold_at = -1;
    int          hold_len = 0;
    int          hold_left = 0;
    logic [31:0] held_addr = '0;
    bit          unstable = 0;
    bit          ovf = 0;

    initial begin
        mem_ack_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) model_outst = 0;
            if (rst_n && mem_req_o && model_outst >= 4) ovf = 1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (pipe_a.size() > 0 && pipe_t[0] <= ncyc && !(gap_en && $urandom_range(0, 1) == 0)) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = {pipe_a[0], ~pipe_a[0]};
                void'(pipe_a.pop_front());
                void'(pipe_t.pop_front());
                if (model_outst > 0) model_outst--;
            end
            mem_ack_i = 1'b0;
            if (rst_n && mem_req_o) begin
                if (acked.size() == hold_at && hold_left > 0) begin
                    if (hold_left == hold_len) held_addr = mem_addr_o;
                    else if (mem_addr_o !== held_addr) unstable = 1;
                    hold_left--;
                end else begin
                    mem_ack_i = 1'b1;
                    acked.push_back(mem_addr_o);
                    pipe_a.push_back(mem_addr_o);
                    pipe_t.push_back(ncyc + 2);
                    model_outst++;
                end
            end
        end
    end

    // Output monitor.
    logic [DW-1:0] rx[$];
    int            mon_cyc = 0;
    int            done_cnt = 0;
    int            done_at = 0;
    int            last_valid_at = 0;
    bit            done_with_valid = 0;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (ext_valid_o) begin
                rx.push_back(ext_data_o);
                last_valid_at = mon_cyc;
                if (ext_done_o) done_with_valid = 1;
            end
            if (ext_done_o) begin
                done_cnt++;
                done_at = mon_cyc;
            end
        end
    end

    task automatic run_load(input logic [7:0] x, input logic [7:0] y, input logic [31:0] row0,
                            input bit change_x, input string tag);
        int  cyc;
        bit  got_done;
        logic [31:0] e;
        acked.delete();
        rx.delete();
        done_cnt = 0;
        done_with_valid = 0;
        ovf = 0;
        unstable = 0;
        @(negedge clk);
        ext_mb_x_i  = x;
        ext_mb_y_i  = y;
        ext_start_i = 1'b1;
        cyc = 0;
        got_done = 0;
        while (!got_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ext_done_o) got_done = 1;
            if (change_x && rx.size() == 6) ext_mb_x_i = x + 8'd3;
        end
        check({tag, " done_seen"}, 64'(got_done), 64'd1);
        @(negedge clk);
        check({tag, " no_retrig1"}, 64'(mem_req_o), 64'd0);
        @(negedge clk);
        check({tag, " no_retrig2"}, 64'(mem_req_o), 64'd0);
        @(negedge clk);
        ext_start_i = 1'b0;
        check({tag, " ack_count"}, 64'(acked.size()), 64'd32);
        check({tag, " beat_count"}, 64'(rx.size()), 64'd32);
        for (int k = 0; k < 32; k++) begin
            e = exp_addr(row0, k);
            if (k < acked.size()) check($sformatf("%s addr%0d", tag, k), 64'(acked[k]), 64'(e));
            if (k < rx.size()) check($sformatf("%s data%0d", tag, k), rx[k], {e, ~e});
        end
        check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, " done_with_valid"}, 64'(done_with_valid), 64'd0);
        check({tag, " done_after_last"}, 64'(done_at > last_valid_at), 64'd1);
        check({tag, " outst_le_max"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        int          cyc;
        int          n_at_rst;
        int          acks_at_rst;
        logic [31:0] clamp_row0;

        rst_n          = 1'b0;
        ext_start_i    = 1'b0;
        ext_mb_x_i     = '0;
        ext_mb_y_i     = '0;
        sys_total_x    = 8'd9;
        sys_total_y    = 8'd5;
        sys_ref_base_i = BASE;

        repeat (3) @(negedge clk);
        check("rst valid", 64'(ext_valid_o), 64'd0);
        check("rst data", ext_data_o, 64'd0);
        check("rst done", 64'(ext_done_o), 64'd0);
        check("rst req", 64'(mem_req_o), 64'd0);
        check("rst addr", 64'(mem_addr_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_load(8'd2, 8'd1, 32'h1A20, 0, "basic");
        if (acked.size() == 32) begin
            check("basic beat0", 64'(acked[0]), 64'h1A20);
            check("basic beat1", 64'(acked[1]), 64'h1AC0);
            check("basic beat4", 64'(acked[4]), 64'h1A28);
            check("basic beat8", 64'(acked[8]), 64'h1CA0);
            check("basic beat31", 64'(acked[31]), 64'h2388);
        end

        run_load(8'd0, 8'd0, BASE, 0, "b2b");
        if (acked.size() > 0) check("b2b beat0", 64'(acked[0]), 64'h1000);

        gap_en    = 1;
        hold_at   = 3;
        hold_len  = 5;
        hold_left = 5;
        run_load(8'd2, 8'd1, 32'h1A20, 0, "bp");
        check("bp held_addr", 64'(held_addr), 64'h1C00);
        check("bp addr_stable", 64'(unstable), 64'd0);
        check("bp hold_done", 64'(hold_left), 64'd0);
        gap_en  = 0;
        hold_at = -1;

        run_load(8'd2, 8'd1, 32'h1A20, 1, "xchg");

        acked.delete();
        rx.delete();
        @(negedge clk);
        ext_mb_x_i  = 8'd3;
        ext_mb_y_i  = 8'd0;
        ext_start_i = 1'b1;
        cyc = 0;
        while (rx.size() < 11 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid reached_beat10", 64'(rx.size() >= 11), 64'd1);
        rst_n       = 1'b0;
        ext_start_i = 1'b0;
        #1;
        n_at_rst    = rx.size();
        acks_at_rst = acked.size();
        check("rst_mid valid", 64'(ext_valid_o), 64'd0);
        check("rst_mid done", 64'(ext_done_o), 64'd0);
        check("rst_mid req", 64'(mem_req_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid no_stray_valid", 64'(rx.size()), 64'(n_at_rst));
        check("rst_mid no_new_req", 64'(acked.size()), 64'(acks_at_rst));
        check("rst_mid data", ext_data_o, 64'd0);

        run_load(8'd1, 8'd2, 32'h2410, 0, "post_rst");

`ifdef FETCH_EXT_CLAMP_EN
        clamp_row0 = BASE + 32'd5 * 32'd2560 + 32'd144;
`else
        clamp_row0 = BASE + 32'd7 * 32'd2560 + 32'd192;
`endif
        run_load(8'd12, 8'd7, clamp_row0, 0, "clamp");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
